noc_port_buffer: RTL and testbench
==================================

# noc_port_buffer

Input port buffer that sits directly upstream of the `noc` router on each link (left and right). It captures packets from a link using the same strobe style the router already uses (`*_in` data plus `*_en` strobe) and queues them in a FIFO. It presents the packets to the router crossbar with a valid/ready handshake, a decoded direction field and a per-pop credit back to the sender. Overflow is detected, counted and flagged rather than silently corrupting the queue.

## Interface
- `PACKET_SIZE`, 8: packet width in bits; bits [1:0] are the destination field.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy counter width (derived, not overridden).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `link_in` input PACKET_SIZE: packet from the upstream link.
- `link_en` input 1: write strobe; qualified only when exactly 1 (X/Z treated as idle in sim, tied low at integration).
- `out_data` output PACKET_SIZE: head-of-queue packet.
- `out_valid` output 1: head entry valid.
- `out_dir` output 2: `out_data[1:0]`, the router output-select field.
- `out_ready` input 1: router accepts the head this cycle.
- `credit` output 1: one-cycle pulse per popped entry.
- `count` output CNT_W: current occupancy.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `overflow` output 1: sticky, set on the first dropped packet.
- `drop_cnt` output 8: saturating count of dropped packets.

## Operation
- Push: `link_en`==1 at a rising edge and (not full, or a pop occurs in the same edge) writes `link_in` at the write pointer, then the write pointer increments.
- Pop: `out_valid && out_ready` at a rising edge increments the read pointer. `credit` is 1 during the following cycle only.
- Drop: `link_en`==1 while full with no pop in the same edge discards the packet. `overflow` is set to 1 and stays set until reset; `drop_cnt` increments and saturates at 255.
- Pointers are log2(DEPTH) bits wide and wrap naturally. `count` tracks occupancy: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- `out_data` is read combinationally from the memory at the read pointer. `out_valid` = !empty. `out_dir` = `out_data[1:0]` with encodings 00 local, 01 left, 10 right, 11 reserved. Reserved packets are queued and presented unchanged; the router decides what to do with them.
- There is no fall-through path: a packet pushed into an empty FIFO is first visible one cycle later.
- Reset (asynchronous, at any time): pointers = 0, count = 0, `empty`=1, `full`=0, `out_valid`=0, `credit`=0, `overflow`=0, `drop_cnt`=0. Stored contents are discarded, and `out_data` is don't-care while `empty`. Mid-operation reset drops `out_valid` immediately, without waiting for a clock edge.

## Timing
- Push-to-`out_valid` latency: 1 cycle.
- Pop-to-`credit` pulse: 1 cycle, exactly 1 cycle wide. Back-to-back pops produce a continuous `credit` high.
- `full`/`empty`/`count` update on the same edge as the push or pop that causes the change.
- Full with simultaneous push and pop: both are accepted, `count` stays at DEPTH, no drop.
- Empty with `out_ready`=1: no pop and no credit.
- Sustained throughput: 1 packet per cycle when `out_ready` is held high.

## Structure
- Shared package `noc_pkg` holds `PACKET_SIZE` and the direction constants `DIR_LOCAL`, `DIR_LEFT`, `DIR_RIGHT`, `DIR_RSVD`. The router uses the same constants.
- Sub-module `noc_fifo_mem`: a DEPTH x PACKET_SIZE register array with a synchronous write port and an asynchronous read port. It has no reset on the data.
- The top level holds the pointers, count, flags, credit and drop logic.

## Test plan
- Reset, then a single push of 8'h03 → `out_valid`=1 after 1 cycle, `out_dir`=2'b11. With `out_ready`=1, the entry pops, `credit` pulses for 1 cycle, and `empty` returns to 1.
- Push 8'h01, 8'h02, 8'h05, 8'h06 with `out_ready`=0 → `full`=1, `count`=4. A fifth push of 8'h07 → dropped, `overflow`=1, `drop_cnt`=1. Subsequent pops return 01, 02, 05, 06 in order.
- Full FIFO with simultaneous push 8'h09 and pop → no drop, `count` stays 4, and 8'h09 emerges last.
- Continuous pushes of 8'h00..8'h0F with `out_ready`=1 → throughput of 1 per cycle, `count` never exceeds 1, wrap-around preserves order, `credit` stays high for 16 cycles.
- 300 pushes while full and not popping → `drop_cnt` saturates at 255 and `overflow` stays 1.
- Assert `rst` mid-burst between clock edges → `out_valid`, `count` and `overflow` go to 0 immediately. The first post-reset push of 8'h0A is the first packet popped.

Source files
------------

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC router and its link-side port buffers.
//   PACKET_SIZE : packet width in bits; bits [1:0] carry the destination field
//   DIR_*       : encodings of the destination field (router output select)
// -----------------------------------------------------------------------------
package noc_pkg;

   localparam int PACKET_SIZE = 8;

   localparam logic [1:0] DIR_LOCAL = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;
   localparam logic [1:0] DIR_RSVD  = 2'b11;

endpackage

// File: rtl/noc_fifo_mem.sv
// -----------------------------------------------------------------------------
// noc_fifo_mem
// DEPTH x WIDTH register array backing the port buffer queue.
// The data is not reset; validity is tracked by the owner's pointers/count.
// Ports:
//   clk     : clock, rising edge
//   i_we    : write enable, samples i_wdata into entry i_waddr
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : asynchronous read data of entry i_raddr
// -----------------------------------------------------------------------------
module noc_fifo_mem #(
   parameter int WIDTH = noc_pkg::PACKET_SIZE,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [PTR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [PTR_W-1:0] i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/noc_port_buffer.sv
// -----------------------------------------------------------------------------
// noc_port_buffer
// Link-side input buffer in front of the NoC router. Captures strobed packets
// from the link into a FIFO, presents the head to the crossbar and returns one
// credit per consumed packet. Packets arriving while full are dropped, counted
// and flagged.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   link_in   : packet from upstream link
//   link_en   : link write strobe (only a clean 1 is a write)
//   out_data  : head-of-queue packet (don't-care while empty)
//   out_valid : head entry valid
//   out_dir   : out_data[1:0], router output select
//   out_ready : router accepts the head this cycle
//   credit    : one-cycle pulse in the cycle after each pop
//   count     : current occupancy
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, set by the first dropped packet
//   drop_cnt  : saturating count of dropped packets
//
// Handshake: a transfer happens at a rising edge where out_valid and out_ready
// are both 1. out_valid never depends on out_ready, and out_data/out_dir stay
// stable while out_valid is 1 and no transfer has occurred.
// -----------------------------------------------------------------------------
module noc_port_buffer
   import noc_pkg::*;
#(
   parameter int PACKET_SIZE = noc_pkg::PACKET_SIZE,
   parameter int DEPTH       = 4,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PACKET_SIZE-1:0] link_in,
   input  logic                   link_en,
   output logic [PACKET_SIZE-1:0] out_data,
   output logic                   out_valid,
   output logic [1:0]             out_dir,
   input  logic                   out_ready,
   output logic                   credit,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic [7:0]             drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_credit;
   logic             r_overflow;
   logic [7:0]       r_drop_cnt;

   logic             w_link_en;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // Case equality so an X/Z strobe in simulation reads as idle.
   assign w_link_en = (link_en === 1'b1);

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   assign w_pop  = !w_empty && out_ready;
   // A pop on the same edge frees the slot, so a full queue still accepts.
   assign w_push = w_link_en && (!w_full || w_pop);
   assign w_drop = w_link_en && w_full && !w_pop;

   noc_fifo_mem #(
      .WIDTH (PACKET_SIZE),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (link_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (out_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_credit   <= 1'b0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_credit <= w_pop;

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
               r_drop_cnt <= r_drop_cnt + 8'd1;
            end
         end
      end
   end

   // Derived from the async-reset count so out_valid drops as soon as rst rises.
   assign out_valid = !w_empty;
   assign out_dir   = out_data[1:0];
   assign credit    = r_credit;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_noc_port_buffer.sv
// -----------------------------------------------------------------------------
// tb_noc_port_buffer
// Bench for noc_port_buffer: a queue-based reference model updated on every
// clock edge, a negedge compare process, and directed scenarios with literal
// expectations.
// -----------------------------------------------------------------------------
module tb_noc_port_buffer;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic [7:0]       link_in;
   logic             link_en;
   logic [7:0]       out_data;
   logic             out_valid;
   logic [1:0]       out_dir;
   logic             out_ready;
   logic             credit;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic [7:0]       drop_cnt;

   noc_port_buffer #(.PACKET_SIZE(8), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .link_in   (link_in),
      .link_en   (link_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_dir   (out_dir),
      .out_ready (out_ready),
      .credit    (credit),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   bit         m_overflow;
   int         m_drops;
   bit         m_credit;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_overflow = 1'b0;
         m_drops    = 0;
         m_credit   = 1'b0;
      end else begin
         bit do_pop;
         bit wr;
         do_pop = (exp_q.size() > 0) && (out_ready === 1'b1);
         wr     = (link_en === 1'b1);
         m_credit = do_pop;
         if (do_pop) void'(exp_q.pop_front());
         if (wr) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(link_in);
            else begin
               m_overflow = 1'b1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
   end

   // ---------------- compare + monitor ----------------
   logic [7:0] popped[$];
   int         credit_run = 0;
   int         max_credit_run = 0;
   int         max_count = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         chk("count",     32'(count),     32'(exp_q.size()));
         chk("full",      32'(full),      32'(exp_q.size() == DEPTH));
         chk("empty",     32'(empty),     32'(exp_q.size() == 0));
         chk("credit",    32'(credit),    32'(m_credit));
         chk("overflow",  32'(overflow),  32'(m_overflow));
         chk("drop_cnt",  32'(drop_cnt),  32'(m_drops));
         if (exp_q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            chk("out_dir",  32'(out_dir),  32'(exp_q[0] & 8'h03));
         end
      end
      if (!rst && out_valid && out_ready) popped.push_back(out_data);
      if (credit) credit_run++;
      else        credit_run = 0;
      if (credit_run > max_credit_run) max_credit_run = credit_run;
      if (int'(count) > max_count) max_count = int'(count);
   end

   // ---------------- driver ----------------
   // Called at posedge+2; applies inputs for the next edge, returns at the
   // following posedge+2 with the outputs settled.
   task automatic cyc(input logic en, input logic [7:0] d, input logic rdy);
      link_en   = en;
      link_in   = d;
      out_ready = rdy;
      @(posedge clk);
      #2;
   endtask

   task automatic check_popped(input string name, input logic [7:0] exp[$]);
      chk({name, "_len"}, 32'(popped.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < popped.size(); i++)
         chk(name, 32'(popped[i]), 32'(exp[i]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] e[$];
      rst = 1'b0; link_en = 1'b0; link_in = '0; out_ready = 1'b0;
      #1 rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // reset state
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_drop",  32'(drop_cnt), 32'd0);

      // single reserved-direction packet
      cyc(1'b1, 8'h03, 1'b0);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_dir",   32'(out_dir), 32'd3);
      cyc(1'b0, 8'h00, 1'b1);
      chk("t1_credit", 32'(credit), 32'd1);
      chk("t1_empty",  32'(empty), 32'd1);
      cyc(1'b0, 8'h00, 1'b0);
      chk("t1_credit_end", 32'(credit), 32'd0);

      // fill, overflow, drain in order
      cyc(1'b1, 8'h01, 1'b0);
      cyc(1'b1, 8'h02, 1'b0);
      cyc(1'b1, 8'h05, 1'b0);
      cyc(1'b1, 8'h06, 1'b0);
      chk("t2_full",  32'(full), 32'd1);
      chk("t2_count", 32'(count), 32'd4);
      cyc(1'b1, 8'h07, 1'b0);
      chk("t2_ovf",  32'(overflow), 32'd1);
      chk("t2_drop", 32'(drop_cnt), 32'd1);
      popped.delete();
      repeat (4) cyc(1'b0, 8'h00, 1'b1);
      e = '{8'h01, 8'h02, 8'h05, 8'h06};
      check_popped("t2_order", e);
      chk("t2_empty", 32'(empty), 32'd1);

      // full with simultaneous push and pop
      cyc(1'b1, 8'h11, 1'b0);
      cyc(1'b1, 8'h12, 1'b0);
      cyc(1'b1, 8'h13, 1'b0);
      cyc(1'b1, 8'h14, 1'b0);
      popped.delete();
      cyc(1'b1, 8'h09, 1'b1);
      chk("t3_count", 32'(count), 32'd4);
      chk("t3_drop",  32'(drop_cnt), 32'd1);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);
      e = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h09};
      check_popped("t3_order", e);

      // streaming at one packet per cycle
      cyc(1'b0, 8'h00, 1'b0);
      popped.delete();
      max_credit_run = 0;
      max_count = 0;
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b1);
      repeat (3) cyc(1'b0, 8'h00, 1'b1);
      e.delete();
      for (int i = 0; i < 16; i++) e.push_back(8'(i));
      check_popped("t4_order", e);
      chk("t4_max_count",  32'(max_count), 32'd1);
      chk("t4_credit_run", 32'(max_credit_run), 32'd16);

      // drop counter saturation
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
      for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i), 1'b0);
      chk("t5_drop", 32'(drop_cnt), 32'd255);
      chk("t5_ovf",  32'(overflow), 32'd1);

      // asynchronous reset mid-burst
      cyc(1'b1, 8'h20, 1'b1);
      link_en = 1'b0; out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_ovf",   32'(overflow), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      popped.delete();
      cyc(1'b1, 8'h0A, 1'b0);
      cyc(1'b1, 8'h0B, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("t6_first_len", 32'(popped.size() > 0), 32'd1);
      if (popped.size() > 0) chk("t6_first", 32'(popped[0]), 32'h0A);
      cyc(1'b0, 8'h00, 1'b0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
